npc_lsu_mc: RTL and testbench
=============================

Name: npc_lsu_mc

Overview:
- Multi-cycle load/store unit; the next generation of the single-cycle LSU in the npc core.
- Accepts one memory op per handshake from the decode stage and drives a valid/ready request channel to the data cache.
- Waits for the cache response, then aligns and extends load data and emits a one-cycle register write-back pulse.
- Parametrised in data width, with byte-lane masking, a response timeout and selectable misalignment handling.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 64, data bus width; legal values 32 or 64
REG_ADDR_WIDTH, 5, register index width
TIMEOUT_CYCLES, 255, max cycles in WAIT before abort; minimum 1

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
req_valid_idu_i  in  1  op request from decode
req_ready_idu_o  out  1  LSU can accept an op
req_ls_idu_i  in  1  1=store, 0=load
req_addr_idu_i  in  ADDR_WIDTH  byte address
req_wdth_idu_i  in  2  size: 00=B, 01=H, 10=W, 11=D
req_unsigned_idu_i  in  1  zero-extend load when 1
req_st_dat_idu_i  in  DATA_WIDTH  store data, LSB-justified
req_rd_idu_i  in  REG_ADDR_WIDTH  load destination register
dc_req_valid_o  out  1  cache request valid
dc_req_ready_i  in  1  cache accepts request
dc_addr_o  out  ADDR_WIDTH  bus-aligned address
dc_we_o  out  1  write enable
dc_wmask_o  out  DATA_WIDTH/8  byte strobes
dc_wdat_o  out  DATA_WIDTH  lane-shifted store data
dc_rsp_valid_i  in  1  response / store ack
dc_rsp_dat_i  in  DATA_WIDTH  raw bus read data
wrtbck_en_idu_o  out  1  one-cycle write-back strobe
rd_idu_o  out  REG_ADDR_WIDTH  write-back register
wrtbck_dat_idu_o  out  DATA_WIDTH  extended load data
err_o  out  1  one-cycle pulse on timeout or illegal op

Behaviour:
- Reset: all outputs 0 except req_ready_idu_o=1. FSM enters IDLE; captured op and timeout counter clear. Reset mid-operation abandons the op silently, with no write-back and no err_o.
- Operating states: IDLE, REQ, WAIT.
- Request handshake: an op is accepted on a cycle where req_valid_idu_i and req_ready_idu_o are both high. Request fields are registered at acceptance.
- req_ready_idu_o is high only in IDLE.
- IDLE->REQ on accept. dc_req_valid_o rises the next cycle and holds, with all dc_* fields stable, until dc_req_ready_i is high.
- REQ->WAIT on the cache handshake. The timeout counter loads 0.
- WAIT->IDLE on dc_rsp_valid_i:
  - Load with rd!=0: wrtbck_en_idu_o=1 for exactly that cycle, with rd_idu_o and wrtbck_dat_idu_o valid in the same cycle.
  - Store, or load with rd=0: no write-back.
- dc_rsp_valid_i and dc_req_ready_i are ignored outside WAIT and REQ respectively.
- Timeout: the counter increments each WAIT cycle without a response. Reaching TIMEOUT_CYCLES forces WAIT->IDLE, pulses err_o and produces no write-back. A response arriving on the same cycle as the timeout wins, so there is no err_o.
- Best-case latency: accept at t, cache handshake at t+1, response at t+2, write-back at t+2. The op occupies 3 cycles; there is no overlap between ops.
- Lanes: NB=DATA_WIDTH/8, off=addr[log2(NB)-1:0], size=1<<wdth.
  - dc_addr_o = addr with low log2(NB) bits zeroed.
  - dc_wmask_o = ((1<<size)-1)<<off; 0 for loads.
  - dc_wdat_o = st_dat<<(8*off).
  - Load data = (rsp>>(8*off)) truncated to size bytes, then sign- or zero-extended to DATA_WIDTH.
- Illegal op: wdth=11 with DATA_WIDTH=32. The LSU pulses err_o in the cycle after acceptance, returns to IDLE, and issues no cache request.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: an access with off not a multiple of size, or off+size>NB, is handled like an illegal op. The LSU pulses err_o one cycle after acceptance, issues no cache request and returns to IDLE.
- Undefined: the low log2(size) address bits are forced to 0 before lane computation, so the access is silently aligned down and never errors.

Test Plan:
- DATA_WIDTH=64. Load B at 0x80000003, unsigned=0, rsp=0x00000000_AB000000 -> dc_addr_o=0x80000000; write-back 0xFFFFFFFF_FFFFFFAB at rd=5.
- Store H, data 0x1234, addr 0x80000006 -> dc_wmask_o=0xC0, dc_wdat_o=0x1234_0000_0000_0000, dc_we_o=1; no write-back after ack.
- Load W, unsigned=1, rd=0, rsp=0xFFFFFFFF_80000000 at addr 0x80000004 -> no wrtbck_en_idu_o; FSM returns to IDLE.
- dc_req_ready_i held low 4 cycles -> dc_req_valid_o and dc_addr_o stable for all 4 cycles; req_ready_idu_o stays 0.
- TIMEOUT_CYCLES=3 with no response -> err_o pulses on the 3rd WAIT cycle; req_ready_idu_o=1 on the next cycle; a response arriving exactly at timeout gives a write-back instead.
- LSU_MISALIGN_TRAP_EN defined, load W at 0x80000002 -> err_o pulses, no dc_req_valid_o. Undefined -> dc_addr_o=0x80000000, off treated as 0.

Source files
------------

// File: rtl/npc_lsu_mc.sv
// Multi-cycle load/store unit: decode handshake -> cache request -> response -> write-back.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning them down.
module npc_lsu_mc #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid_idu_i,
  output logic                      req_ready_idu_o,
  input  logic                      req_ls_idu_i,
  input  logic [ADDR_WIDTH-1:0]     req_addr_idu_i,
  input  logic [1:0]                req_wdth_idu_i,
  input  logic                      req_unsigned_idu_i,
  input  logic [DATA_WIDTH-1:0]     req_st_dat_idu_i,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd_idu_i,
  output logic                      dc_req_valid_o,
  input  logic                      dc_req_ready_i,
  output logic [ADDR_WIDTH-1:0]     dc_addr_o,
  output logic                      dc_we_o,
  output logic [DATA_WIDTH/8-1:0]   dc_wmask_o,
  output logic [DATA_WIDTH-1:0]     dc_wdat_o,
  input  logic                      dc_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]     dc_rsp_dat_i,
  output logic                      wrtbck_en_idu_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_idu_o,
  output logic [DATA_WIDTH-1:0]     wrtbck_dat_idu_o,
  output logic                      err_o
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic                      ls;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [1:0]                wdth;
    logic                      uns;
    logic [DATA_WIDTH-1:0]     st_dat;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } op_t;

  state_e          state_q, state_d;
  op_t             op_q, op_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Lane decode, all derived from the captured op so dc_* stay stable under backpressure.
  logic [OFFW-1:0]       off_raw, off, size_m1;
  logic [NB-1:0]         size_bmask;
  logic [DATA_WIDTH-1:0] val_mask, rsp_sh, load_ext;
  logic                  sgn, illegal, misalign, bad_op;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    size_m1    = '0;
    size_bmask = '0;
    val_mask   = '1;
    sgn        = 1'b0;
    off_raw    = op_q.addr[OFFW-1:0];

    case (op_q.wdth)
      2'b00: begin
        size_m1    = OFFW'(0);
        size_bmask = NB'(8'h01);
      end
      2'b01: begin
        size_m1    = OFFW'(1);
        size_bmask = NB'(8'h03);
      end
      2'b10: begin
        size_m1    = OFFW'(3);
        size_bmask = NB'(8'h0F);
      end
      2'b11: begin
        size_m1    = OFFW'(7);
        size_bmask = NB'(8'hFF);
      end
    endcase

    illegal  = (NB == 4) && (op_q.wdth == 2'b11);
    misalign = ((off_raw & size_m1) != '0) ||
               ((int'(off_raw) + int'(size_m1)) > (NB - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    bad_op = illegal || misalign;
    off    = off_raw;
`else
    bad_op = illegal;
    off    = off_raw & ~size_m1;
`endif

    rsp_sh = dc_rsp_dat_i >> {off, 3'b000};
    case (op_q.wdth)
      2'b00: begin
        val_mask = DATA_WIDTH'(64'h0000_0000_0000_00FF);
        sgn      = rsp_sh[7];
      end
      2'b01: begin
        val_mask = DATA_WIDTH'(64'h0000_0000_0000_FFFF);
        sgn      = rsp_sh[15];
      end
      2'b10: begin
        val_mask = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
        sgn      = rsp_sh[31];
      end
      2'b11: begin
        val_mask = '1;
        sgn      = rsp_sh[DATA_WIDTH-1];
      end
    endcase
    load_ext = (rsp_sh & val_mask) | ((sgn && !op_q.uns) ? ~val_mask : '0);
  end

  assign dc_addr_o  = {op_q.addr[ADDR_WIDTH-1:OFFW], OFFW'(0)};
  assign dc_we_o    = op_q.ls;
  assign dc_wmask_o = op_q.ls ? (size_bmask << off) : '0;
  assign dc_wdat_o  = op_q.st_dat << {off, 3'b000};

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    cnt_d           = cnt_q;
    req_ready_idu_o = 1'b0;
    dc_req_valid_o  = 1'b0;
    wrtbck_en_idu_o = 1'b0;
    err_o           = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_idu_o = 1'b1;
        if (req_valid_idu_i) begin
          op_d = '{ls:     req_ls_idu_i,
                   addr:   req_addr_idu_i,
                   wdth:   req_wdth_idu_i,
                   uns:    req_unsigned_idu_i,
                   st_dat: req_st_dat_idu_i,
                   rd:     req_rd_idu_i};
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Rejected ops never reach the cache; they report one cycle after acceptance.
        if (bad_op) begin
          err_o   = 1'b1;
          state_d = S_IDLE;
        end else begin
          dc_req_valid_o = 1'b1;
          if (dc_req_ready_i) begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A response on the timeout cycle takes priority over the abort.
        if (dc_rsp_valid_i) begin
          wrtbck_en_idu_o = !op_q.ls && (op_q.rd != '0);
          state_d         = S_IDLE;
        end else if (cnt_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
          err_o   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_idu_o         = wrtbck_en_idu_o ? op_q.rd : '0;
  assign wrtbck_dat_idu_o = wrtbck_en_idu_o ? load_ext : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_npc_lsu_mc.sv
// Directed bench for npc_lsu_mc: vector table for single ops plus hand-written multi-cycle sequences.
module tb_npc_lsu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // 64-bit instance, short timeout
  logic        req_valid, req_ready, req_ls, req_uns;
  logic [31:0] req_addr;
  logic [1:0]  req_wdth;
  logic [63:0] req_st;
  logic [4:0]  req_rd;
  logic        dc_req_valid, dc_req_ready, dc_we, dc_rsp_valid;
  logic [31:0] dc_addr;
  logic [7:0]  dc_wmask;
  logic [63:0] dc_wdat, dc_rsp_dat;
  logic        wb_en, err;
  logic [4:0]  wb_rd;
  logic [63:0] wb_dat;

  npc_lsu_mc #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_idu_i(req_valid), .req_ready_idu_o(req_ready), .req_ls_idu_i(req_ls),
    .req_addr_idu_i(req_addr), .req_wdth_idu_i(req_wdth), .req_unsigned_idu_i(req_uns),
    .req_st_dat_idu_i(req_st), .req_rd_idu_i(req_rd),
    .dc_req_valid_o(dc_req_valid), .dc_req_ready_i(dc_req_ready), .dc_addr_o(dc_addr),
    .dc_we_o(dc_we), .dc_wmask_o(dc_wmask), .dc_wdat_o(dc_wdat),
    .dc_rsp_valid_i(dc_rsp_valid), .dc_rsp_dat_i(dc_rsp_dat),
    .wrtbck_en_idu_o(wb_en), .rd_idu_o(wb_rd), .wrtbck_dat_idu_o(wb_dat), .err_o(err)
  );

  // 32-bit instance for the illegal doubleword op
  logic        s_req_valid, s_req_ready, s_req_ls, s_req_uns;
  logic [31:0] s_req_addr;
  logic [1:0]  s_req_wdth;
  logic [31:0] s_req_st;
  logic [4:0]  s_req_rd;
  logic        s_dc_req_valid, s_dc_req_ready, s_dc_we, s_dc_rsp_valid;
  logic [31:0] s_dc_addr;
  logic [3:0]  s_dc_wmask;
  logic [31:0] s_dc_wdat, s_dc_rsp_dat;
  logic        s_wb_en, s_err;
  logic [4:0]  s_wb_rd;
  logic [31:0] s_wb_dat;

  npc_lsu_mc #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(255)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_idu_i(s_req_valid), .req_ready_idu_o(s_req_ready), .req_ls_idu_i(s_req_ls),
    .req_addr_idu_i(s_req_addr), .req_wdth_idu_i(s_req_wdth), .req_unsigned_idu_i(s_req_uns),
    .req_st_dat_idu_i(s_req_st), .req_rd_idu_i(s_req_rd),
    .dc_req_valid_o(s_dc_req_valid), .dc_req_ready_i(s_dc_req_ready), .dc_addr_o(s_dc_addr),
    .dc_we_o(s_dc_we), .dc_wmask_o(s_dc_wmask), .dc_wdat_o(s_dc_wdat),
    .dc_rsp_valid_i(s_dc_rsp_valid), .dc_rsp_dat_i(s_dc_rsp_dat),
    .wrtbck_en_idu_o(s_wb_en), .rd_idu_o(s_wb_rd), .wrtbck_dat_idu_o(s_wb_dat), .err_o(s_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present an op in IDLE, confirm ready, leave the DUT in REQ with req_valid dropped.
  task automatic issue(input logic ls, input logic [31:0] addr, input logic [1:0] wdth,
                       input logic uns, input logic [63:0] st, input logic [4:0] rd);
    req_valid = 1'b1; req_ls = ls; req_addr = addr; req_wdth = wdth;
    req_uns = uns; req_st = st; req_rd = rd;
    @(negedge clk);
    check("accept_ready", req_ready, 1);
    next_cycle();
    req_valid = 1'b0;
  endtask

  // Issue and complete the cache handshake immediately; ends on the first WAIT cycle.
  task automatic to_wait(input logic [31:0] addr, input logic [1:0] wdth, input logic [4:0] rd);
    issue(1'b0, addr, wdth, 1'b0, 64'h0, rd);
    dc_req_ready = 1'b1;
    next_cycle();
    dc_req_ready = 1'b0;
  endtask

  typedef struct {
    logic        ls;
    logic [31:0] addr;
    logic [1:0]  wdth;
    logic        uns;
    logic [63:0] st;
    logic [4:0]  rd;
    logic [63:0] rsp;
    logic [31:0] e_addr;
    logic [7:0]  e_wmask;
    logic [63:0] e_wdat;
    logic        e_wb;
    logic [63:0] e_wbdat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, 32'h8000_0003, 2'b00, 1'b0, 64'h0, 5'd5, 64'h0000_0000_AB00_0000,
                 32'h8000_0000, 8'h00, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFAB};
    vecs[1]  = '{1'b1, 32'h8000_0006, 2'b01, 1'b0, 64'h1234, 5'd7, 64'hDEAD_BEEF_DEAD_BEEF,
                 32'h8000_0000, 8'hC0, 64'h1234_0000_0000_0000, 1'b0, 64'h0};
    vecs[2]  = '{1'b0, 32'h8000_0004, 2'b10, 1'b1, 64'h0, 5'd0, 64'hFFFF_FFFF_8000_0000,
                 32'h8000_0000, 8'h00, 64'h0, 1'b0, 64'h0};
    vecs[3]  = '{1'b0, 32'h8000_0004, 2'b10, 1'b1, 64'h0, 5'd3, 64'hFFFF_FFFF_8000_0000,
                 32'h8000_0000, 8'h00, 64'h0, 1'b1, 64'h0000_0000_FFFF_FFFF};
    vecs[4]  = '{1'b0, 32'h8000_0000, 2'b10, 1'b0, 64'h0, 5'd4, 64'h1234_5678_8000_0001,
                 32'h8000_0000, 8'h00, 64'h0, 1'b1, 64'hFFFF_FFFF_8000_0001};
    vecs[5]  = '{1'b0, 32'h8000_0002, 2'b01, 1'b1, 64'h0, 5'd9, 64'h0000_0000_8765_0000,
                 32'h8000_0000, 8'h00, 64'h0, 1'b1, 64'h0000_0000_0000_8765};
    vecs[6]  = '{1'b0, 32'h8000_0008, 2'b11, 1'b0, 64'h0, 5'd31, 64'h0123_4567_89AB_CDEF,
                 32'h8000_0008, 8'h00, 64'h0, 1'b1, 64'h0123_4567_89AB_CDEF};
    vecs[7]  = '{1'b1, 32'h8000_0011, 2'b00, 1'b0, 64'hA5, 5'd0, 64'h0,
                 32'h8000_0010, 8'h02, 64'hA500, 1'b0, 64'h0};
    vecs[8]  = '{1'b1, 32'h8000_0020, 2'b11, 1'b0, 64'h1122_3344_5566_7788, 5'd0, 64'h0,
                 32'h8000_0020, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 64'h0};
    vecs[9]  = '{1'b1, 32'h8000_000C, 2'b10, 1'b0, 64'hCAFE_BABE, 5'd0, 64'h0,
                 32'h8000_0008, 8'hF0, 64'hCAFE_BABE_0000_0000, 1'b0, 64'h0};
    vecs[10] = '{1'b0, 32'h8000_0007, 2'b00, 1'b1, 64'h0, 5'd1, 64'h8000_0000_0000_0000,
                 32'h8000_0000, 8'h00, 64'h0, 1'b1, 64'h0000_0000_0000_0080};
    vecs[11] = '{1'b0, 32'h8000_0006, 2'b01, 1'b0, 64'h0, 5'd2, 64'h8001_0000_0000_0000,
                 32'h8000_0000, 8'h00, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_8001};

    rst_n = 1'b0;
    req_valid = 0; req_ls = 0; req_addr = '0; req_wdth = '0; req_uns = 0; req_st = '0; req_rd = '0;
    dc_req_ready = 0; dc_rsp_valid = 0; dc_rsp_dat = '0;
    s_req_valid = 0; s_req_ls = 0; s_req_addr = '0; s_req_wdth = '0; s_req_uns = 0;
    s_req_st = '0; s_req_rd = '0; s_dc_req_ready = 0; s_dc_rsp_valid = 0; s_dc_rsp_dat = '0;

    // Reset state
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_dc_req_valid", dc_req_valid, 0);
    check("rst_dc_addr", dc_addr, 0);
    check("rst_dc_we", dc_we, 0);
    check("rst_dc_wmask", dc_wmask, 0);
    check("rst_dc_wdat", dc_wdat, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_dat", wb_dat, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    next_cycle();

    // Single ops at best-case latency
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].ls, vecs[i].addr, vecs[i].wdth, vecs[i].uns, vecs[i].st, vecs[i].rd);
      dc_req_ready = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d dc_req_valid", i), dc_req_valid, 1);
      check($sformatf("v%0d dc_addr", i), dc_addr, vecs[i].e_addr);
      check($sformatf("v%0d dc_we", i), dc_we, vecs[i].ls);
      check($sformatf("v%0d dc_wmask", i), dc_wmask, vecs[i].e_wmask);
      check($sformatf("v%0d dc_wdat", i), dc_wdat, vecs[i].e_wdat);
      check($sformatf("v%0d busy_ready", i), req_ready, 0);
      next_cycle();
      dc_req_ready = 1'b0;
      dc_rsp_valid = 1'b1;
      dc_rsp_dat   = vecs[i].rsp;
      @(negedge clk);
      check($sformatf("v%0d wb_en", i), wb_en, vecs[i].e_wb);
      check($sformatf("v%0d wb_rd", i), wb_rd, vecs[i].e_wb ? vecs[i].rd : 5'd0);
      check($sformatf("v%0d wb_dat", i), wb_dat, vecs[i].e_wbdat);
      check($sformatf("v%0d err", i), err, 0);
      next_cycle();
      dc_rsp_valid = 1'b0;
      dc_rsp_dat   = '0;
      @(negedge clk);
      check($sformatf("v%0d idle_ready", i), req_ready, 1);
      check($sformatf("v%0d idle_wb_en", i), wb_en, 0);
      next_cycle();
    end

    // Cache backpressure: request held stable, stray responses in REQ ignored
    issue(1'b0, 32'h8000_0014, 2'b10, 1'b0, 64'h0, 5'd10);
    dc_rsp_valid = 1'b1;
    dc_rsp_dat   = 64'h0000_0042_0000_0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d dc_req_valid", c), dc_req_valid, 1);
      check($sformatf("bp%0d dc_addr", c), dc_addr, 32'h8000_0010);
      check($sformatf("bp%0d req_ready", c), req_ready, 0);
      check($sformatf("bp%0d wb_en", c), wb_en, 0);
      next_cycle();
    end
    dc_rsp_valid = 1'b0;
    dc_req_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", dc_req_valid, 1);
    next_cycle();
    dc_req_ready = 1'b0;
    dc_rsp_valid = 1'b1;
    @(negedge clk);
    check("bp_wb_en", wb_en, 1);
    check("bp_wb_dat", wb_dat, 64'h42);
    next_cycle();
    dc_rsp_valid = 1'b0;

    // Timeout with no response
    to_wait(32'h8000_0000, 2'b00, 5'd12);
    @(negedge clk); check("to_w1_err", err, 0);
    next_cycle();
    @(negedge clk); check("to_w2_err", err, 0);
    next_cycle();
    @(negedge clk); check("to_w3_err", err, 1); check("to_w3_wb", wb_en, 0);
    next_cycle();
    @(negedge clk); check("to_after_ready", req_ready, 1); check("to_after_err", err, 0);
    next_cycle();

    // Response on the timeout cycle wins
    to_wait(32'h8000_0000, 2'b00, 5'd12);
    dc_rsp_dat = 64'h7F;
    @(negedge clk); check("tr_w1_err", err, 0);
    next_cycle();
    @(negedge clk); check("tr_w2_err", err, 0);
    next_cycle();
    dc_rsp_valid = 1'b1;
    @(negedge clk);
    check("tr_w3_err", err, 0);
    check("tr_w3_wb", wb_en, 1);
    check("tr_w3_dat", wb_dat, 64'h7F);
    next_cycle();
    dc_rsp_valid = 1'b0;
    @(negedge clk); check("tr_after_ready", req_ready, 1);
    next_cycle();

    // Misaligned word load
    issue(1'b0, 32'h8000_0002, 2'b10, 1'b0, 64'h0, 5'd8);
    dc_req_ready = 1'b1;
    @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_err", err, 1);
    check("mis_dc_req_valid", dc_req_valid, 0);
    next_cycle();
    dc_req_ready = 1'b0;
    @(negedge clk);
    check("mis_after_ready", req_ready, 1);
    check("mis_after_err", err, 0);
    next_cycle();
`else
    check("mis_err", err, 0);
    check("mis_dc_req_valid", dc_req_valid, 1);
    check("mis_dc_addr", dc_addr, 32'h8000_0000);
    next_cycle();
    dc_req_ready = 1'b0;
    dc_rsp_valid = 1'b1;
    dc_rsp_dat   = 64'h1122_3344_5566_7788;
    @(negedge clk);
    check("mis_wb_en", wb_en, 1);
    check("mis_wb_dat", wb_dat, 64'h5566_7788);
    next_cycle();
    dc_rsp_valid = 1'b0;
`endif

    // Illegal doubleword on the 32-bit instance
    s_req_valid = 1'b1; s_req_wdth = 2'b11; s_req_addr = 32'h8000_0000; s_req_rd = 5'd6;
    s_dc_req_ready = 1'b1;
    @(negedge clk); check("ill_accept_ready", s_req_ready, 1);
    next_cycle();
    s_req_valid = 1'b0;
    @(negedge clk);
    check("ill_err", s_err, 1);
    check("ill_dc_req_valid", s_dc_req_valid, 0);
    next_cycle();
    @(negedge clk);
    check("ill_after_ready", s_req_ready, 1);
    check("ill_after_err", s_err, 0);
    next_cycle();

    // Legal halfword load on the 32-bit instance
    s_req_valid = 1'b1; s_req_wdth = 2'b01; s_req_addr = 32'h8000_0002; s_req_rd = 5'd6;
    next_cycle();
    s_req_valid = 1'b0;
    @(negedge clk);
    check("s_dc_req_valid", s_dc_req_valid, 1);
    check("s_dc_addr", s_dc_addr, 32'h8000_0000);
    check("s_dc_we", s_dc_we, 0);
    check("s_dc_wmask", s_dc_wmask, 0);
    check("s_dc_wdat", s_dc_wdat, 0);
    next_cycle();
    s_dc_req_ready = 1'b0;
    s_dc_rsp_valid = 1'b1;
    s_dc_rsp_dat   = 32'hBEEF_0000;
    @(negedge clk);
    check("s_wb_en", s_wb_en, 1);
    check("s_wb_rd", s_wb_rd, 5'd6);
    check("s_wb_dat", s_wb_dat, 32'hFFFF_BEEF);
    next_cycle();
    s_dc_rsp_valid = 1'b0;

    // Reset in WAIT abandons the op silently
    to_wait(32'h8000_0000, 2'b10, 5'd3);
    dc_rsp_valid = 1'b1;
    dc_rsp_dat   = 64'h1;
    rst_n = 1'b0;
    #1;
    check("mrst_req_ready", req_ready, 1);
    check("mrst_wb_en", wb_en, 0);
    check("mrst_err", err, 0);
    check("mrst_dc_req_valid", dc_req_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_idle_wb_en", wb_en, 0);
    dc_rsp_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    check("mrst_after_ready", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
